// File: rtl/display_7seg_sequencial_if.sv
// Handshake and display bus for display_7seg_sequencial.
// master: producer of binary values (drives in_valid/in_data).
// slave : the display driver.
interface display_7seg_sequencial_if #(
    parameter int BIN_WIDTH  = 20,
    parameter int NUM_DIGITS = 6
);
    logic                    in_valid;
    logic [BIN_WIDTH-1:0]    in_data;
    logic                    in_ready;
    logic                    done;
    logic                    overflow;
    logic [7*NUM_DIGITS-1:0] segmentos;

    modport master (
        output in_valid, in_data,
        input  in_ready, done, overflow, segmentos
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, done, overflow, segmentos
    );
endinterface

// File: rtl/display_7seg_sequencial.sv
// Sequential binary -> BCD (shift-and-add-3, one bit per clock) -> active-low
// seven-segment driver for NUM_DIGITS displays.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero digit (digit 0 and overflow dashes are never blanked).
module display_7seg_sequencial #(
    parameter int BIN_WIDTH  = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic clk,
    input  logic rst_n,
    display_7seg_sequencial_if.slave bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} state_t;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic                 acc_q, acc_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic [SEG_W-1:0]     seg_q, seg_d;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD nibble
    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    // Full display image; overflow forces dashes on every digit
    function automatic logic [SEG_W-1:0] render(input logic [BCD_W-1:0] bcd,
                                                input logic ovf);
        logic [SEG_W-1:0] res;
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        res  = '1;
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (ovf) begin
                res[7*k +: 7] = 7'b0111111;
            end else if (lead && bcd[4*k +: 4] == 4'd0 && k != 0) begin
                res[7*k +: 7] = 7'b1111111;
            end else begin
                res[7*k +: 7] = enc(bcd[4*k +: 4]);
                lead          = 1'b0;
            end
        end
`else
        res = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            res[7*k +: 7] = ovf ? 7'b0111111 : enc(bcd[4*k +: 4]);
        end
`endif
        return res;
    endfunction

    // Add-3 correction of every nibble >= 5 ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Next-state logic: accept, convert one bit per cycle, then publish
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        seg_d   = seg_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.in_valid && ready_q) begin
                    bin_d   = bus.in_data;
                    bcd_d   = '0;
                    acc_d   = 1'b0;
                    cnt_d   = 6'(BIN_WIDTH);
                    ready_d = 1'b0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // bit leaving the top of the BCD field means too many digits
                acc_d = acc_q | bcd_adj[BCD_W-1];
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                seg_d   = render(bcd_q, acc_q);
                ovf_d   = acc_q;
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any conversion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;
    assign bus.segmentos = seg_q;
endmodule

// File: tb/tb_display_7seg_sequencial.sv
// Self-checking bench: default 20-bit/6-digit instance plus a 4-bit/1-digit one.
module tb_display_7seg_sequencial;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    display_7seg_sequencial_if #(.BIN_WIDTH(20), .NUM_DIGITS(6)) m_if ();
    display_7seg_sequencial_if #(.BIN_WIDTH(4),  .NUM_DIGITS(1)) s_if ();

    display_7seg_sequencial #(.BIN_WIDTH(20), .NUM_DIGITS(6)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(m_if));
    display_7seg_sequencial #(.BIN_WIDTH(4), .NUM_DIGITS(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(s_if));

    typedef struct {
        logic [19:0] din;
        logic [41:0] seg;
        logic        ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [6:0] pat(input longint unsigned d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference: decimal digits by division, dashes when value >= 10^nd
    function automatic logic [69:0] model(input longint unsigned v, input int nd,
                                          output logic ovf);
        logic [69:0] r;
        longint unsigned p;
        r = '1;
        p = 1;
        for (int k = 0; k < nd; k++) p = p * 10;
        ovf = (v >= p);
        p = 1;
        for (int k = 0; k < nd; k++) begin
            if (ovf) r[7*k +: 7] = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
            else if (k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
`endif
            else r[7*k +: 7] = pat((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // One conversion on the wide instance; entered and left at a negedge
    task automatic run_main(input logic [19:0] v, input logic [41:0] es,
                            input logic eo, input string nm);
        int n;
        int busy_bad;
        n = 0;
        while (!m_if.in_ready && n < 50) begin @(negedge clk); n++; end
        chk({nm, " ready_before"}, 70'(m_if.in_ready), 70'd1);
        m_if.in_valid = 1'b1;
        m_if.in_data  = v;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        m_if.in_data  = 20'($urandom);
        n = 0;
        busy_bad = 0;
        while (!m_if.done && n < 40) begin
            if (m_if.in_ready) busy_bad++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " busy_ready_low"}, 70'(busy_bad), 70'd0);
        chk({nm, " latency"}, 70'(n), 70'd21);
        chk({nm, " seg"}, 70'(m_if.segmentos), 70'(es));
        chk({nm, " ovf"}, 70'(m_if.overflow), 70'(eo));
        chk({nm, " ready_with_done"}, 70'(m_if.in_ready), 70'd1);
        @(posedge clk); #1;
        chk({nm, " done_one_cycle"}, 70'(m_if.done), 70'd0);
        chk({nm, " seg_hold"}, 70'(m_if.segmentos), 70'(es));
        @(negedge clk);
    endtask

    task automatic run_small(input logic [3:0] v, input logic [6:0] es,
                             input logic eo, input string nm);
        int n;
        s_if.in_valid = 1'b1;
        s_if.in_data  = v;
        @(posedge clk); #1;
        s_if.in_valid = 1'b0;
        s_if.in_data  = 4'($urandom);
        n = 0;
        while (!s_if.done && n < 20) begin @(posedge clk); #1; n++; end
        chk({nm, " latency"}, 70'(n), 70'd5);
        chk({nm, " seg"}, 70'(s_if.segmentos), 70'(es));
        chk({nm, " ovf"}, 70'(s_if.overflow), 70'(eo));
        @(negedge clk);
    endtask

    initial begin
        vec_t        tbl[5];
        logic [19:0] v;
        logic [69:0] es;
        logic        eo;
        logic        rb;
        int          last_acc;
        int          accepts;
        int          dcount;
        logic [19:0] q[$];

        tbl[0] = '{20'd123456, {7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010}, 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[1] = '{20'd0, {{5{7'b1111111}}, 7'b1000000}, 1'b0};
`else
        tbl[1] = '{20'd0, {6{7'b1000000}}, 1'b0};
`endif
        tbl[2] = '{20'd1000000, {6{7'b0111111}}, 1'b1};
        tbl[3] = '{20'd999999,  {6{7'b0010000}}, 1'b0};
        tbl[4] = '{20'hFFFFF,   {6{7'b0111111}}, 1'b1};

        rst_n = 1'b0;
        m_if.in_valid = 1'b0; m_if.in_data = '0;
        s_if.in_valid = 1'b0; s_if.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", 70'(m_if.in_ready), 70'd1);
        chk("rst done", 70'(m_if.done), 70'd0);
        chk("rst ovf", 70'(m_if.overflow), 70'd0);
        chk("rst seg", 70'(m_if.segmentos), 70'({42{1'b1}}));
        chk("rst small seg", 70'(s_if.segmentos), 70'h7f);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_main(tbl[i].din, tbl[i].seg, tbl[i].ovf, "table");

        for (int i = 0; i < 25; i++) begin
            v  = ($urandom % 4 == 0) ? 20'($urandom_range(0, 99)) : 20'($urandom);
            es = model(longint'(v), 6, eo);
            run_main(v, es[41:0], eo, "random");
        end

        // Sustained valid with data changing every cycle
        last_acc = -1;
        accepts  = 0;
        for (int cyc = 0; cyc < 140; cyc++) begin
            m_if.in_valid = (cyc < 115);
            m_if.in_data  = 20'($urandom);
            rb = m_if.in_ready & m_if.in_valid;
            v  = m_if.in_data;
            @(posedge clk);
            if (rb) begin
                q.push_back(v);
                if (last_acc >= 0) chk("stream spacing", 70'(cyc - last_acc), 70'd22);
                last_acc = cyc;
                accepts++;
            end
            #1;
            if (m_if.done) begin
                chk("stream ready_with_done", 70'(m_if.in_ready), 70'd1);
                if (q.size() == 0) begin
                    chk("stream spurious done", 70'd1, 70'd0);
                end else begin
                    v  = q.pop_front();
                    es = model(longint'(v), 6, eo);
                    chk("stream seg", 70'(m_if.segmentos), 70'(es[41:0]));
                    chk("stream ovf", 70'(m_if.overflow), 70'(eo));
                end
            end
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        chk("stream accepts", 70'(accepts), 70'd6);
        chk("stream drained", 70'(q.size()), 70'd0);

        // Reset in the middle of a conversion (accept at T, reset edge T+10)
        m_if.in_valid = 1'b1;
        m_if.in_data  = 20'd777777;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst ready", 70'(m_if.in_ready), 70'd1);
        chk("midrst seg", 70'(m_if.segmentos), 70'({42{1'b1}}));
        chk("midrst ovf", 70'(m_if.overflow), 70'd0);
        chk("midrst done", 70'(m_if.done), 70'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (m_if.done) dcount++;
        end
        chk("midrst no_done", 70'(dcount), 70'd0);
        @(negedge clk);
        es = model(64'd654321, 6, eo);
        run_main(20'd654321, es[41:0], eo, "after_rst");

        // Narrow instance: 4-bit input, single digit
        run_small(4'd15, 7'b0111111, 1'b1, "small15");
        run_small(4'd9,  7'b0010000, 1'b0, "small9");
        run_small(4'd10, 7'b0111111, 1'b1, "small10");
        run_small(4'd0,  7'b1000000, 1'b0, "small0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/display_7seg_sequencial.md
# display_7seg_sequencial

Sequential binary-to-seven-segment display driver, parametrised in input width and digit count. It accepts a binary value over a valid/ready handshake and converts it to BCD iteratively with shift-and-add-3, one bit per clock. It then registers active-low segment patterns for every digit. It sits between the score/timer logic and the board's HEX displays, replacing the fixed 6-digit combinational BCD decoder.

## Interface
Parameters:
- BIN_WIDTH, 20: width of the binary input; legal range 1..32.
- NUM_DIGITS, 6: number of decimal digits/displays driven; legal range 1..10.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- in_valid  input  1  a binary value is offered on in_data.
- in_data  input  BIN_WIDTH  unsigned binary value to display.
- in_ready  output  1  block is idle and will accept a value.
- done  output  1  one-cycle pulse when the segment outputs have been updated.
- overflow  output  1  last converted value was ≥ 10^NUM_DIGITS; held until the next update.
- segmentos  output  7*NUM_DIGITS  active-low segment patterns.
  - Digit k (k=0 is least significant) is on bits [7k+6:7k].
  - Bit order within a digit is {g,f,e,d,c,b,a}.

## Operation
- FSM has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the shift register, clear the BCD register (4*NUM_DIGITS bits) and the overflow accumulator, load the bit counter with BIN_WIDTH, and go to CONVERT.
  - CONVERT: in_ready=0. Each cycle:
    - Add 3 to every BCD nibble ≥ 5.
    - Shift {BCD, binary} left by one.
    - OR the bit shifted out of the BCD MSB into the overflow accumulator.
    - Decrement the counter.
    - When the counter reaches 0 after this step, go to UPDATE.
  - UPDATE: encode every nibble and register it into segmentos, copy the accumulator to overflow, pulse done, go to IDLE.
- Encoding (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any nibble >9 encodes as 1111111. This cannot occur in correct operation.
- Overflow: a 1 shifted out of the BCD MSB means the value needs more than NUM_DIGITS digits.
  - On overflow, every digit shows dash 0111111, regardless of configuration.
- in_data is sampled only at the handshake; later changes are ignored.
- in_valid is ignored while in_ready=0; no queueing.
- segmentos and overflow change only in UPDATE and hold between conversions.

## Timing
- Reset (rst_n low at a rising edge), applied from any state:
  - Values: state=IDLE, in_ready=1, done=0, overflow=0, segmentos all 1 (all segments off).
  - A conversion in progress is abandoned and produces no done pulse.
- Handshake accepted at edge T:
  - CONVERT edges are T+1 .. T+BIN_WIDTH.
  - UPDATE edge is T+BIN_WIDTH+1; segmentos, overflow and done become valid after it.
  - done is high for exactly one cycle.
  - in_ready returns high in that same cycle.
- Earliest next accept is edge T+BIN_WIDTH+2. Sustained throughput is one value per BIN_WIDTH+2 cycles.
- in_ready is low from the cycle after the accept until the cycle done is high.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: during UPDATE, every digit above the most significant non-zero digit is driven 1111111.
    - Digit 0 is never blanked, so a value of 0 shows a single "0".
    - Overflow dashes are not blanked.
  - Undefined: all NUM_DIGITS digits are displayed, including leading zeros.

## Test plan
- Defaults, in_data=123456 → after 21 edges: done pulse; digits 5..0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010; overflow=0.
- in_data=0 → digit0=1000000 in both builds; digits 1..5 = 1111111 with LEADING_ZERO_BLANK_EN, 1000000 without it.
- in_data=1000000 (BIN_WIDTH=20, NUM_DIGITS=6) → overflow=1; all six digits 0111111; a following in_data=999999 clears overflow and shows six 9s (0010000).
- in_valid held high continuously with changing in_data → accepts exactly every 22 cycles; in_ready and done coincide; each result matches the in_data sampled at its own accept edge.
- rst_n low for one edge at T+10 mid-conversion → next cycle in_ready=1, segmentos all 1, overflow=0, no done pulse; a new conversion afterwards completes correctly.
- BIN_WIDTH=4, NUM_DIGITS=1, in_data=15 → overflow=1, digit 0111111, done 5 edges after accept.
